m_flat_top: RTL and testbench

Self-contained JPEG-2000 5/3 lifting demonstrator that works on one 144-bit flattened row of sixteen 9-bit samples.
- After reset it loads a built-in sample vector.
- It applies one integer predict step, then one integer update step.
- It shifts the 144-bit result out serially on sdo, MSB first.
- It is the top of the parallel-JPEG flat datapath experiment; its only observable output is sdo.

---
 rtl/m_flat_pkg.sv | 30 +++
 rtl/m_flat_lift.sv | 44 ++++
 rtl/m_flat_top.sv | 90 +++++++++
 tb/tb_m_flat_top.sv | 134 +++++++++++++
 4 files changed

// File: rtl/m_flat_pkg.sv
// +------------------------------------------------------------------+
// | m_flat_pkg : shared types and constants for the 5/3 flat datapath|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package m_flat_pkg;

    localparam int W  = 9;
    localparam int N  = 16;
    localparam int FW = W * N;

    localparam logic [FW-1:0] INIT = 144'h001c0000000000000001c000000000000000;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        PREDICT = 3'd1,
        UPDATE  = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Lane k lives at bits [W*k +: W]; lane 0 sits at the LSB.
    function automatic logic signed [W-1:0] lane_get(input logic [FW-1:0] v, input int k);
        return v[W*k +: W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_flat_lift.sv
// +------------------------------------------------------------------+
// | m_flat_lift : one combinational 5/3 lifting step (predict/update)|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module m_flat_lift
    import m_flat_pkg::*;
(
    input  logic          i_mode,   // 0 = predict odd lanes, 1 = update even lanes
    input  logic [FW-1:0] i_vec,
    output logic [FW-1:0] o_vec
);

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            // Symmetric mirror at both ends: lane -1 -> lane 1, lane N -> lane N-2.
            localparam int LEFT  = (k == 0)     ? 1     : k - 1;
            localparam int RIGHT = (k == N - 1) ? N - 2 : k + 1;

            logic signed [W-1:0] w_cur, w_left, w_right, w_res;
            logic signed [W+1:0] w_cur_x, w_nsum;

            assign w_cur   = lane_get(i_vec, k);
            assign w_left  = lane_get(i_vec, LEFT);
            assign w_right = lane_get(i_vec, RIGHT);
            assign w_cur_x = {{2{w_cur[W-1]}}, w_cur};

            if (k % 2 == 1) begin : g_odd
                assign w_nsum = {{2{w_left[W-1]}}, w_left} + {{2{w_right[W-1]}}, w_right};
                assign w_res  = W'(w_cur_x - (w_nsum >>> 1));
                assign o_vec[W*k +: W] = i_mode ? w_cur : w_res;
            end else begin : g_even
                assign w_nsum = {{2{w_left[W-1]}}, w_left} + {{2{w_right[W-1]}}, w_right} + 11'sd2;
                assign w_res  = W'(w_cur_x + (w_nsum >>> 2));
                assign o_vec[W*k +: W] = i_mode ? w_res : w_cur;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/m_flat_top.sv
// +------------------------------------------------------------------+
// | m_flat_top : 5/3 lifting demonstrator, serial MSB-first result   |
// | Option FLAT_MULTILEVEL_EN: repeat passes on the previous result. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module m_flat_top
    import m_flat_pkg::*;
(
    input  logic clock,
    input  logic reset,
    output logic sdo
);

`ifdef FLAT_MULTILEVEL_EN
    // One trailing zero-fill edge keeps the frame period at 147 cycles.
    localparam logic [7:0] C_LAST_CNT    = 8'd144;
    localparam state_t     C_AFTER_SHIFT = PREDICT;
`else
    localparam logic [7:0] C_LAST_CNT    = 8'd143;
    localparam state_t     C_AFTER_SHIFT = DONE;
`endif

    state_t        r_state;
    logic [FW-1:0] r_flat;
    logic [FW-1:0] r_sreg;
    logic [7:0]    r_cnt;
    logic          r_sdo;
    logic [FW-1:0] w_lift;
    logic          w_mode;

    assign w_mode = (r_state == UPDATE);

    m_flat_lift u_lift (
        .i_mode (w_mode),
        .i_vec  (r_flat),
        .o_vec  (w_lift)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= LOAD;
            r_flat  <= '0;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_sdo   <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_flat  <= INIT;
                    r_sdo   <= 1'b0;
                    r_state <= PREDICT;
                end
                PREDICT: begin
                    r_flat  <= w_lift;
                    r_sdo   <= 1'b0;
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    r_flat  <= w_lift;
                    r_sreg  <= w_lift;
                    r_cnt   <= '0;
                    r_sdo   <= 1'b0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_sdo  <= r_sreg[FW-1];
                    r_sreg <= {r_sreg[FW-2:0], 1'b0};
                    r_cnt  <= r_cnt + 8'd1;
                    if (r_cnt == C_LAST_CNT) begin
                        r_state <= C_AFTER_SHIFT;
                    end
                end
                DONE: begin
                    r_sdo <= 1'b0;
                end
                default: begin
                    r_sdo   <= 1'b0;
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign sdo = r_sdo;

endmodule

`default_nettype wire

// File: tb/tb_m_flat_top.sv
// +------------------------------------------------------------------+
// | tb_m_flat_top : scoreboard bench for the 5/3 flat demonstrator   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_m_flat_top;
    import m_flat_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sdo;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    logic [143:0] frame1, frame2, frame3;
    int exp_lane[16] = '{0, 0, 0, 0, 32, 128, -191, 131, 33, 0, 0, 0, -14, -56, 70, -112};

    always #5 clock = ~clock;

    m_flat_top u_dut (
        .clock (clock),
        .reset (reset),
        .sdo   (sdo)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference 5/3 predict then update on sixteen 9-bit lanes, wrapping to 9 bits.
    function automatic logic [143:0] lift_model(input logic [143:0] v);
        int a[16];
        logic [143:0] t;
        int l, r;
        for (int k = 0; k < 16; k++) a[k] = int'($signed(v[9*k +: 9]));
        for (int k = 1; k < 16; k += 2) begin
            r = (k == 15) ? a[14] : a[k+1];
            a[k] = a[k] - ((a[k-1] + r) >>> 1);
        end
        for (int k = 0; k < 16; k++) t[9*k +: 9] = a[k][8:0];
        for (int k = 0; k < 16; k++) a[k] = int'($signed(t[9*k +: 9]));
        for (int k = 0; k < 16; k += 2) begin
            l = (k == 0) ? a[1] : a[k-1];
            a[k] = a[k] + ((l + a[k+1] + 2) >>> 2);
        end
        for (int k = 0; k < 16; k++) t[9*k +: 9] = a[k][8:0];
        return t;
    endfunction

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check("q_empty", 1, 0);
        end else begin
            check(tag, int'(sdo), int'(exp_q.pop_front()));
        end
    endtask

    // Runs edges 1..last after reset release; abort_at != 0 pulses reset at that edge.
    task automatic run(input int abort_at, output logic [143:0] frame);
        logic [143:0] e1, e2;
        int last;
        e1 = lift_model(INIT);
        e2 = lift_model(e1);
        frame = '0;
        for (int i = 143; i >= 0; i--) exp_q.push_back(e1[i]);
`ifdef FLAT_MULTILEVEL_EN
        for (int i = 143; i >= 0; i--) exp_q.push_back(e2[i]);
        last = 297;
`else
        last = 155;
`endif
        for (int e = 1; e <= last; e++) begin
            if (abort_at != 0 && e == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                check("rst_mid_sdo", int'(sdo), 0);
                reset = 1'b0;
                exp_q.delete();
                return;
            end
            @(posedge clock); #1;
            if (e <= 3) begin
                check("pre_shift_sdo", int'(sdo), 0);
            end else if (e <= 147) begin
                frame[147-e] = sdo;
                pop_check("sdo_frame1");
`ifdef FLAT_MULTILEVEL_EN
            end else if (e >= 151 && e <= 294) begin
                pop_check("sdo_frame2");
`endif
            end else begin
                check("idle_sdo", int'(sdo), 0);
            end
        end
        check("q_leftover", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("reset_sdo", int'(sdo), 0);
        end
        reset = 1'b0;

        run(0, frame1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("lane%0d", k), int'($signed(frame1[9*k +: 9])), exp_lane[k]);
        end

        reset = 1'b1;
        @(posedge clock); #1;
        check("reset2_sdo", int'(sdo), 0);
        reset = 1'b0;

        run(60, frame2);
        run(0, frame3);
        check("rerun_identical", int'(frame3 == frame1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
